// File: rtl/exec_issue_ctrl.sv
// Issue/writeback controller: queues 9-bit instructions, issues registered operands
// to Decode_And_Execute and writes the combinational result back one cycle later.
`timescale 1ns/1ps

module exec_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [8:0] in_instr,
    output logic       in_ready,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] rs,
    output logic [3:0] rt,
    output logic [2:0] sel,
    input  logic [3:0] rd,
    output logic       wb_valid,
    output logic [1:0] wb_addr,
    output logic [3:0] wb_data,
    output logic [7:0] retire_cnt,
    output logic       busy,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          issue;
    logic          retire;

    logic [8:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic [8:0]    head;

    logic [3:0]    regs [4];
    logic [1:0]    dst_q;

    assign in_ready = (count != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr];
    assign busy     = (state != IDLE) || (count != '0);
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    issue     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: FIFO storage is left unreset; pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_instr;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register file: an EXEC writeback takes priority over a direct load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (retire && dst_q == 2'(i))
                    regs[i] <= rd;
                else if (ld_en && ld_addr == 2'(i))
                    regs[i] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs         <= '0;
            rt         <= '0;
            sel        <= '0;
            dst_q      <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else begin
            wb_valid <= retire;
            if (issue) begin
                rs    <= regs[head[3:2]];
                rt    <= regs[head[1:0]];
                sel   <= head[8:6];
                dst_q <= head[5:4];
            end
            if (retire) begin
                wb_addr    <= dst_q;
                wb_data    <= rd;
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Scoreboard bench for exec_issue_ctrl with an adder stub standing in for Decode_And_Execute.
`timescale 1ns/1ps

module tb_exec_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [2:0] sel;
    logic [3:0] rd;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic [7:0] retire_cnt;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       mon_e;
    logic [7:0] sb_cnt;
    int         wb_cycles [$];
    int         cyc;
    int         total;
    int         bad;
    int         held;

    exec_issue_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rs         (rs),
        .rt         (rt),
        .sel        (sel),
        .rd         (rd),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt),
        .busy       (busy),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    assign rd = rs + rt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            wb_cycles.push_back(cyc);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got addr=%0d data=%0h required no writeback", wb_addr, wb_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(mon_e.addr));
                check("wb_data", 32'(wb_data), 32'(mon_e.data));
                check("wb_retire_cnt", 32'(retire_cnt), 32'(mon_e.cnt));
            end
        end
    end

    function automatic logic [8:0] mk(input int op, input int dst, input int a, input int b);
        return {3'(op), 2'(dst), 2'(a), 2'(b)};
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ld_en    = 1'b0;
        #1;
        sb_q.delete();
        sb_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic push_instr(input logic [8:0] instr, input logic [1:0] ea, input logic [3:0] ed,
                              output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready=0 required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_cnt = sb_cnt + 1'b1;
        sb_q.push_back('{addr: ea, data: ed, cnt: sb_cnt});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got busy=%0d pending=%0d required 0", busy, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input logic [1:0] a, input logic [3:0] e);
        dbg_addr = a;
        #1;
        check($sformatf("reg%0d", a), 32'(dbg_data), 32'(e));
    endtask

    logic [8:0] fill_instr [8];
    logic [1:0] fill_addr  [8];
    logic [3:0] fill_data  [8];
    logic [3:0] chain_data [4];

    initial begin
        cyc      = 0;
        total    = 0;
        bad      = 0;
        sb_cnt   = '0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        dbg_addr = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #3;
        check("rst_rs", 32'(rs), 0);
        check("rst_rt", 32'(rt), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_retire_cnt", 32'(retire_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add: R1=3, R2=5, R3 <= R1+R2
        load(2'd1, 4'd3);
        load(2'd2, 4'd5);
        push_instr(mk(0, 3, 1, 2), 2'd3, 4'd8, held);
        @(posedge clk);
        @(negedge clk);
        check("issue_rs", 32'(rs), 3);
        check("issue_rt", 32'(rt), 5);
        check("issue_sel", 32'(sel), 0);
        drain();
        check_reg(2'd3, 4'd8);
        check("basic_retire_cnt", 32'(retire_cnt), 1);

        // Dependent chain on R1 (starts at 1): 2,4,8,0
        do_reset();
        load(2'd1, 4'd1);
        chain_data = '{4'd2, 4'd4, 4'd8, 4'd0};
        wb_cycles.delete();
        for (int i = 0; i < 4; i++) push_instr(mk(6, 1, 1, 1), 2'd1, chain_data[i], held);
        drain();
        check("chain_retire_cnt", 32'(retire_cnt), 4);
        check("chain_sel_hold", 32'(sel), 6);
        check("chain_wb_count", 32'(wb_cycles.size()), 4);
        for (int i = 1; i < wb_cycles.size(); i++)
            check($sformatf("chain_gap%0d", i), 32'(wb_cycles[i] - wb_cycles[i-1]), 2);
        check_reg(2'd1, 4'd0);

        // FIFO fill and back-pressure: R0..R3 = 1,2,3,4
        do_reset();
        load(2'd0, 4'd1);
        load(2'd1, 4'd2);
        load(2'd2, 4'd3);
        load(2'd3, 4'd4);
        fill_instr = '{mk(0,0,1,2), mk(1,1,0,3), mk(2,2,1,1), mk(3,3,2,0),
                       mk(4,0,3,3), mk(5,1,0,2), mk(6,2,3,0), mk(7,3,2,1)};
        fill_addr  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        fill_data  = '{4'd5, 4'd9, 4'd2, 4'd7, 4'd14, 4'd0, 4'd5, 4'd5};
        for (int i = 0; i < 7; i++) push_instr(fill_instr[i], fill_addr[i], fill_data[i], held);
        check("fill_full_in_ready", 32'(in_ready), 0);
        check("fill_full_busy", 32'(busy), 1);
        push_instr(fill_instr[7], fill_addr[7], fill_data[7], held);
        check("fill_held_cycles", 32'(held), 1);
        drain();
        check("fill_retire_cnt", 32'(retire_cnt), 8);
        check_reg(2'd0, 4'd14);
        check_reg(2'd1, 4'd0);
        check_reg(2'd2, 4'd5);
        check_reg(2'd3, 4'd5);

        // Same-edge load vs writeback
        do_reset();
        load(2'd1, 4'd2);
        load(2'd2, 4'd3);
        push_instr(mk(0, 3, 1, 2), 2'd3, 4'd5, held);
        @(posedge clk);
        #1;
        check("conflict_issue_rs", 32'(rs), 2);
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'hF;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        check_reg(2'd3, 4'd5);
        push_instr(mk(0, 1, 1, 2), 2'd1, 4'd5, held);
        @(posedge clk);
        #1;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'hF;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        check_reg(2'd1, 4'd5);
        check_reg(2'd0, 4'hF);
        drain();

        // Async reset mid-EXEC with two instructions still queued
        do_reset();
        load(2'd1, 4'd1);
        chain_data = '{4'd2, 4'd4, 4'd8, 4'd0};
        for (int i = 0; i < 4; i++) push_instr(mk(0, 1, 1, 1), 2'd1, chain_data[i], held);
        check("pre_reset_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        sb_cnt = '0;
        check("mid_rst_rs", 32'(rs), 0);
        check("mid_rst_rt", 32'(rt), 0);
        check("mid_rst_wb_valid", 32'(wb_valid), 0);
        check("mid_rst_wb_data", 32'(wb_data), 0);
        check("mid_rst_retire_cnt", 32'(retire_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd7;
        in_valid = 1'b1; in_instr = mk(0, 2, 1, 1);
        @(posedge clk);
        #1;
        check("in_rst_in_ready", 32'(in_ready), 1);
        ld_en = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_retire_cnt", 32'(retire_cnt), 0);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 4'h0);

        // 256 retires: counter wraps, busy falls with the last pulse
        do_reset();
        for (int i = 0; i < 256; i++) push_instr(mk(0, 0, 0, 0), 2'd0, 4'd0, held);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wrap_busy", 32'(busy), 0);
        check("wrap_last_wb_valid", 32'(wb_valid), 1);
        check("wrap_retire_cnt", 32'(retire_cnt), 0);
        @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
